// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and synchroniser depth.
// Build with FIFO_RD_SYNC3_EN defined for a 3-flop pointer synchroniser (default 2).
package fifo_pkg;

`ifdef FIFO_RD_SYNC3_EN
  localparam int unsigned FIFO_SYNC_STAGES = 3;
`else
  localparam int unsigned FIFO_SYNC_STAGES = 2;
`endif

  // Values are carried zero-extended in 32 bits; only the low `width` bits are meaningful.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (b ^ (b >> 1)) & mask;
  endfunction

  // XOR prefix from the MSB of the field down.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
    logic [31:0] b;
    logic        acc;
    acc = 1'b0;
    b   = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(width)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchroniser with asynchronous active-low reset; used for the Gray
// pointers crossing between FIFO clock domains.
module sync_nff #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_d [Stages];
  logic [Width-1:0] sync_q [Stages];

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < int'(Stages); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Stages); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(Stages); i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/status controller of the async FIFO. Synchroniser depth follows
// FIFO_RD_SYNC3_EN through fifo_pkg::FIFO_SYNC_STAGES.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rinc,
  input  logic [ADDR_WIDTH:0] wptr,
  output logic [ADDR_WIDTH:0] rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDR_WIDTH:0] rlevel
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AeLevel = PtrW'(AE_LEVEL);

  logic [ADDR_WIDTH:0] rq_wptr;
  logic [ADDR_WIDTH:0] rq_wbin;
  logic                accepted;

  logic [ADDR_WIDTH:0] rbin_d, rbin_q;
  logic [ADDR_WIDTH:0] rptr_d, rptr_q;
  logic [ADDR_WIDTH:0] rlevel_d, rlevel_q;
  logic                rempty_d, rempty_q;
  logic                ralmost_empty_d, ralmost_empty_q;

  sync_nff #(
    .Width  (PtrW),
    .Stages (FIFO_SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (wptr),
    .q_o   (rq_wptr)
  );

  always_comb begin
    accepted        = rinc && !rempty_q;
    rq_wbin         = PtrW'(gray2bin(32'(rq_wptr), PtrW));
    rbin_d          = rbin_q + PtrW'(accepted);
    rptr_d          = PtrW'(bin2gray(32'(rbin_d), PtrW));
    // Empty/level use the next pointer so a last-entry read flags empty on the same edge.
    rempty_d        = (rptr_d == rq_wptr);
    rlevel_d        = rq_wbin - rbin_d;
    ralmost_empty_d = (rlevel_d <= AeLevel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q          <= '0;
      rptr_q          <= '0;
      rlevel_q        <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
    end else begin
      rbin_q          <= rbin_d;
      rptr_q          <= rptr_d;
      rlevel_q        <= rlevel_d;
      rempty_q        <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
    end
  end

  // rptr is a bare flop output so only one bit toggles per read toward the write domain.
  assign rptr          = rptr_q;
  assign raddr         = rbin_q[ADDR_WIDTH-1:0];
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;

endmodule
